// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller: FSM states,
// forwarding selects, valid-bit positions and the supported opcode set.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Bit positions inside vld = {id, ex, mem, wb}
    localparam int unsigned VLD_ID  = 3;
    localparam int unsigned VLD_EX  = 2;
    localparam int unsigned VLD_MEM = 1;
    localparam int unsigned VLD_WB  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    // EX/MEM beats MEM/WB; r0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_ok,
        input logic [4:0] mem_rd,
        input logic       wb_ok,
        input logic [4:0] wb_rd
    );
        if (mem_ok && mem_rd != 5'd0 && mem_rd == src) begin
            return FWD_MEM;
        end else if (wb_ok && wb_rd != 5'd0 && wb_rd == src) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX-stage operand forwarding compare for both ALU inputs.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwr,
    input  logic       mem_vld,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwr,
    input  logic       wb_vld,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic mem_ok;
    logic wb_ok;

    assign mem_ok = mem_vld & mem_regwr;
    assign wb_ok  = wb_vld & wb_regwr;
    assign fwd_a  = fwd_sel(ex_rs, mem_ok, mem_rd, wb_ok, wb_rd);
    assign fwd_b  = fwd_sel(ex_rt, mem_ok, mem_rd, wb_ok, wb_rd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding, stage-valid bits,
// data-memory wait handling with timeout, and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jump,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwr,
    input  logic             ex_memtoreg,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwr,
    input  logic             mem_acc,
    input  logic             dmem_ack,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [3:0]       vld,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [3:0]       vld_q, vld_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_busy;
    logic             load_use;
    logic             memwb_en;

    assign mem_busy = (state_q != StErr) & vld_q[VLD_MEM] & mem_acc & ~dmem_ack;
    assign load_use = ex_memtoreg & ex_regwr & vld_q[VLD_EX] & (ex_rd != 5'd0) &
                      ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        memwb_en    = 1'b1;
        if (state_q == StErr) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    // Valid bits follow the pipe-register enables; IF always fetches a live slot.
    always_comb begin
        vld_d[VLD_ID]  = ifid_flush ? 1'b0 : (ifid_en ? 1'b1 : vld_q[VLD_ID]);
        vld_d[VLD_EX]  = idex_flush ? 1'b0 : (idex_en ? vld_q[VLD_ID] : vld_q[VLD_EX]);
        vld_d[VLD_MEM] = exmem_en ? vld_q[VLD_EX] : vld_q[VLD_MEM];
        vld_d[VLD_WB]  = memwb_flush ? 1'b0 : (memwb_en ? vld_q[VLD_MEM] : vld_q[VLD_WB]);
    end

    // wait_cnt counts unacknowledged wait cycles including the entry cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q != StErr) begin
            if (mem_busy) begin
                state_d    = (wait_cnt_q == WaitLast) ? StErr : StMemWait;
                wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            vld_q       <= 4'b0000;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign vld       = vld_q;
    assign err       = (state_q == StErr);
    assign stall_cnt = stall_cnt_q;

    hazard_fwd_unit u_fwd (
        .ex_rs     (ex_rs),
        .ex_rt     (ex_rt),
        .mem_rd    (mem_rd),
        .mem_regwr (mem_regwr),
        .mem_vld   (vld_q[VLD_MEM]),
        .wb_rd     (wb_rd),
        .wb_regwr  (wb_regwr),
        .wb_vld    (vld_q[VLD_WB]),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: each driven cycle pushes its hand-derived expected
// outputs; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MemTimeout = 4;
    localparam int unsigned CntW       = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
    localparam logic [6:0] CTL_RUN = 7'b1101010;
    localparam logic [6:0] CTL_BR  = 7'b1111110;
    localparam logic [6:0] CTL_LU  = 7'b0001110;
    localparam logic [6:0] CTL_J   = 7'b1111010;
    localparam logic [6:0] CTL_W   = 7'b0000001;
    localparam logic [6:0] CTL_ERR = 7'b0000000;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rs;
        logic       id_use_rt;
        logic       id_jump;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rd;
        logic       ex_regwr;
        logic       ex_memtoreg;
        logic       ex_br_taken;
        logic [4:0] mem_rd;
        logic       mem_regwr;
        logic       mem_acc;
        logic       dmem_ack;
        logic [4:0] wb_rd;
        logic       wb_regwr;
    } stim_t;

    typedef struct packed {
        logic [6:0]      ctl;
        logic [3:0]      fwd;
        logic [3:0]      vld;
        logic            err;
        logic [CntW-1:0] cnt;
    } exp_t;

    logic            clk;
    stim_t           s;
    logic            pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic [1:0]      fwd_a, fwd_b;
    logic [3:0]      vld;
    logic            err;
    logic [CntW-1:0] stall_cnt;

    exp_t exp_q[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step    = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MemTimeout),
        .CNT_W       (CntW)
    ) dut (
        .clk         (clk),
        .rst         (s.rst),
        .id_rs       (s.id_rs),
        .id_rt       (s.id_rt),
        .id_use_rs   (s.id_use_rs),
        .id_use_rt   (s.id_use_rt),
        .id_jump     (s.id_jump),
        .ex_rs       (s.ex_rs),
        .ex_rt       (s.ex_rt),
        .ex_rd       (s.ex_rd),
        .ex_regwr    (s.ex_regwr),
        .ex_memtoreg (s.ex_memtoreg),
        .ex_br_taken (s.ex_br_taken),
        .mem_rd      (s.mem_rd),
        .mem_regwr   (s.mem_regwr),
        .mem_acc     (s.mem_acc),
        .dmem_ack    (s.dmem_ack),
        .wb_rd       (s.wb_rd),
        .wb_regwr    (s.wb_regwr),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .memwb_flush (memwb_flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .vld         (vld),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", tag, step, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [6:0] ctl, input logic [3:0] fwd,
                                input logic [3:0] v, input logic e, input logic [CntW-1:0] c);
        exp_t r;
        r.ctl = ctl;
        r.fwd = fwd;
        r.vld = v;
        r.err = e;
        r.cnt = c;
        return r;
    endfunction

    task automatic go(input stim_t st, input exp_t e);
        @(posedge clk);
        #1;
        s = st;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            step++;
            check("ctl", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                              memwb_flush}), 32'(cur.ctl));
            check("fwd", 32'({fwd_a, fwd_b}), 32'(cur.fwd));
            check("vld", 32'(vld), 32'(cur.vld));
            check("err", 32'(err), 32'(cur.err));
            check("stall_cnt", 32'(stall_cnt), 32'(cur.cnt));
        end
    end

    initial begin
        stim_t z;
        stim_t t;
        z = '0;
        s = '0;
        s.rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state, then pipeline fill
        go(z, mk(CTL_RUN, 4'b0000, 4'b0000, 1'b0, 4'd0));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1000, 1'b0, 4'd0));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1100, 1'b0, 4'd0));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1110, 1'b0, 4'd0));

        // lw r2 in EX, addu r3,r2,r4 in ID
        t = z; t.ex_memtoreg = 1; t.ex_regwr = 1; t.ex_rd = 5'd2; t.ex_rs = 5'd1;
        t.id_rs = 5'd2; t.id_rt = 5'd4; t.id_use_rs = 1; t.id_use_rt = 1;
        go(t, mk(CTL_LU, 4'b0000, 4'b1111, 1'b0, 4'd0));
        t = z; t.mem_rd = 5'd2; t.mem_regwr = 1; t.mem_acc = 1; t.dmem_ack = 1;
        t.ex_rs = 5'd2; t.ex_rt = 5'd4; t.ex_rd = 5'd3; t.ex_regwr = 1;
        go(t, mk(CTL_RUN, 4'b1000, 4'b1011, 1'b0, 4'd1));

        // Forwarding: gap of one (WB), back to back (MEM), both, r0, MEM not writing
        t = z; t.wb_rd = 5'd5; t.wb_regwr = 1; t.ex_rs = 5'd5; t.ex_rt = 5'd5;
        go(t, mk(CTL_RUN, 4'b0101, 4'b1101, 1'b0, 4'd1));
        t = z; t.mem_rd = 5'd5; t.mem_regwr = 1; t.ex_rs = 5'd5; t.ex_rt = 5'd5;
        t.ex_rd = 5'd6; t.ex_regwr = 1;
        go(t, mk(CTL_RUN, 4'b1010, 4'b1110, 1'b0, 4'd1));
        t = z; t.mem_rd = 5'd5; t.mem_regwr = 1; t.wb_rd = 5'd5; t.wb_regwr = 1;
        t.ex_rs = 5'd5; t.ex_rt = 5'd7;
        go(t, mk(CTL_RUN, 4'b1000, 4'b1111, 1'b0, 4'd1));
        t = z; t.mem_regwr = 1; t.wb_regwr = 1;
        go(t, mk(CTL_RUN, 4'b0000, 4'b1111, 1'b0, 4'd1));
        t = z; t.mem_rd = 5'd5; t.wb_rd = 5'd5; t.wb_regwr = 1; t.ex_rs = 5'd5; t.ex_rt = 5'd5;
        go(t, mk(CTL_RUN, 4'b0101, 4'b1111, 1'b0, 4'd1));

        // beq taken in EX, lw-use pair behind it
        t = z; t.ex_br_taken = 1; t.ex_rs = 5'd1; t.ex_rt = 5'd2;
        t.id_rs = 5'd3; t.id_use_rs = 1;
        go(t, mk(CTL_BR, 4'b0000, 4'b1111, 1'b0, 4'd1));
        go(z, mk(CTL_RUN, 4'b0000, 4'b0011, 1'b0, 4'd1));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1001, 1'b0, 4'd1));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1100, 1'b0, 4'd1));

        // sw in MEM, ack low for 3 cycles then ack
        t = z; t.mem_acc = 1;
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd1));
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd2));
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd3));
        t.dmem_ack = 1;
        go(t, mk(CTL_RUN, 4'b0000, 4'b1110, 1'b0, 4'd4));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1111, 1'b0, 4'd4));

        // j in ID concurrent with a mem wait: freeze first, flush on the ack cycle
        t = z; t.id_jump = 1; t.mem_acc = 1;
        go(t, mk(CTL_W, 4'b0000, 4'b1111, 1'b0, 4'd4));
        t.dmem_ack = 1;
        go(t, mk(CTL_J, 4'b0000, 4'b1110, 1'b0, 4'd5));
        go(z, mk(CTL_RUN, 4'b0000, 4'b0111, 1'b0, 4'd5));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1011, 1'b0, 4'd5));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1101, 1'b0, 4'd5));

        // Timeout: 4 unacked cycles then ERR, held; stall_cnt saturates at 15
        t = z; t.mem_acc = 1;
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd5));
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd6));
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd7));
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd8));
        for (int i = 0; i < 8; i++) begin
            t = z; t.mem_acc = 1; t.dmem_ack = i[0];
            go(t, mk(CTL_ERR, 4'b0000, 4'b1110, 1'b1, (i < 7) ? 4'(9 + i) : 4'd15));
        end
        t = z; t.rst = 1;
        go(t, mk(CTL_ERR, 4'b0000, 4'b1110, 1'b1, 4'd15));
        go(z, mk(CTL_RUN, 4'b0000, 4'b0000, 1'b0, 4'd0));

        // Reset in the middle of a mem wait
        go(z, mk(CTL_RUN, 4'b0000, 4'b1000, 1'b0, 4'd0));
        go(z, mk(CTL_RUN, 4'b0000, 4'b1100, 1'b0, 4'd0));
        t = z; t.mem_acc = 1;
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd0));
        t.rst = 1;
        go(t, mk(CTL_W, 4'b0000, 4'b1110, 1'b0, 4'd1));
        go(z, mk(CTL_RUN, 4'b0000, 4'b0000, 1'b0, 4'd0));

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
